alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter DW, default 16, meaning the data width (fixed at 16 for this release).
REQ-002 SHALL have parameter NREG, default 8, meaning the register count (address width 3).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, meaning an asynchronous, active-high reset.
REQ-005 SHALL have port instr_valid / instr_ready, input / output, 1 / 1, meaning the instruction handshake.
REQ-006 SHALL have port instr_op, input, 5, meaning the ALU opcode.
REQ-007 SHALL have ports instr_rd / instr_rs1 / instr_rs2, inputs, 3 each, meaning the destination and source register indices.
REQ-008 SHALL have ports wr_en, wr_addr, wr_data, wr_ready, widths 1/3/16/1 (wr_ready output, others input), meaning the host register load.
REQ-009 SHALL have ports rd_addr and rd_data, input and output, 3 and 16, meaning the combinational register read.
REQ-010 SHALL have ports alu_a, alu_b, alu_f, alu_cin, outputs, 16/16/5/1, meaning the operands driven to the external combinational ALU.
REQ-011 SHALL have ports alu_result and alu_status, inputs, 16 and 6, meaning the ALU result and flags {C,Z,N,V,P,A}.
REQ-012 SHALL have ports done, err, flags, result_out, outputs, 1/1/6/16, meaning completion pulse, illegal-op pulse, flag register, and last result.

Function
REQ-013 SHALL implement FSM IDLE -> ISSUE -> DONE -> IDLE, with one instruction per 3 cycles.
REQ-014 SHALL assert instr_ready and wr_ready only in IDLE; instructions and host writes are accepted only when the respective ready is high.
REQ-015 SHALL, on acceptance (edge E0), register alu_a=R[rs1], alu_b=R[rs2], alu_f=instr_op, and rd, then enter ISSUE.
REQ-016 SHALL drive alu_cin = flags[5] (C) combinationally throughout ISSUE.
REQ-017 SHALL, at the end of ISSUE (edge E1) for a legal opcode: write R[rd]<=alu_result, flags<=alu_status, result_out<=alu_result, and enter DONE.
REQ-018 SHALL treat the following as legal opcodes: 00001, 00011, 00100-00111, 01000-01011, 10000-10111; all others are illegal.
REQ-019 SHALL pulse done high for exactly the DONE cycle (2 cycles after acceptance).
REQ-020 SHALL make rd_data reflect the new R[rd] value from DONE onward.
REQ-021 SHALL, for a simultaneous host write and instruction accept, apply the host write while the instruction's operands use the pre-write values.
REQ-022 SHALL ignore wr_en while wr_ready is low, with no write and no queuing.
REQ-023 SHALL hold alu_a, alu_b, and alu_f stable in DONE and IDLE until the next acceptance.

Reset
REQ-024 SHALL, on rst assertion in any state (including ISSUE and DONE), immediately reach state IDLE with all registers, flags, alu_*, result_out, done, and err cleared to 0, and no pending write performed.
REQ-025 SHALL have instr_ready=1 and wr_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-026 SHALL, with ALU_SEQ_ERR_EN defined, for an illegal opcode at E1: skip the R[rd] write, leave flags and result_out unchanged, pulse err with done in DONE.
REQ-027 SHALL, without ALU_SEQ_ERR_EN, treat every opcode as legal (write and flag update from the ALU outputs) and tie err to 0.

Structure
REQ-028 SHALL place the opcode constants, the legal-opcode function, the flag bit indices (C=5, Z=4, N=3, V=2, P=1, A=0), and the state enum in shared package alu_seq_pkg.
REQ-029 SHALL use one sub-module, alu_seq_regfile (8x16, async reset, 1 write port with host/writeback mux, 3 combinational read ports).

Verification
REQ-030 SHALL cover: load R1=0x7FFF, R2=0x0001; ADD(00100) rd=3 -> R3=0x8000, flags=6'b001101, done exactly 2 cycles after accept.
REQ-031 SHALL cover: R1=0xFFFF, R2=0x0001 ADD rd=4 -> R4=0x0000, C=1; then ADC(00101) rs1=rs2=0 (R0=0) rd=5 -> alu_cin=1, R5=0x0001.
REQ-032 SHALL cover: opcode 01100 rd=3 with ALU_SEQ_ERR_EN -> err and done pulse, R3 and flags unchanged; without the macro -> R3=0x0000, err=0.
REQ-033 SHALL cover: rst pulsed during ISSUE of ADD rd=6 -> R6 stays 0x0000, all outputs 0, instr_ready=1 after release.
REQ-034 SHALL cover: instr_valid and wr_en held during ISSUE/DONE -> neither accepted; instruction accepted on return to IDLE; wr_en is ignored while wr_ready is low and only takes effect if still asserted once back in IDLE.
REQ-035 SHALL cover: same cycle wr R1=0x00AA and INC(00001) rs1=1 rd=2 with old R1=0x0010 -> R2=0x0011, R1=0x00AA.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcodes, flag bit indices, sequencer states and the legal-opcode check.
package alu_seq_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
    localparam logic [4:0] OP_INC = 5'b00001;
    localparam logic [4:0] OP_DEC = 5'b00011;
    localparam logic [2:0] OP_ARITH = 3'b001;
    localparam logic [2:0] OP_LOGIC = 3'b010;
    localparam logic [1:0] OP_SHIFT = 2'b10;
    localparam int FLAG_C = 5;
    localparam int FLAG_Z = 4;
    localparam int FLAG_N = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_P = 1;
    localparam int FLAG_A = 0;
    function automatic logic op_legal(input logic [4:0] op);
        return op == OP_INC || op == OP_DEC || op[4:2] == OP_ARITH || op[4:2] == OP_LOGIC || op[4:3] == OP_SHIFT;
    endfunction
endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: NREG x DW register file, one muxed write port, three combinational read ports.
module alu_seq_regfile #(
    parameter int DW = 16,
    parameter int NREG = 8,
    localparam int AW = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_data,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic [AW-1:0] ra_addr,
    output logic [DW-1:0] ra_data,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] rb_data,
    input  logic [AW-1:0] rc_addr,
    output logic [DW-1:0] rc_data
);
    logic [DW-1:0] regs [NREG];
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    // host writes only happen in IDLE and writeback only in ISSUE, so they never collide
    always_comb begin
        we = host_we | wb_we;
        wa = wb_we ? wb_addr : host_addr;
        wd = wb_we ? wb_data : host_data;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we) begin
            regs[wa] <= wd;
        end
    end
    assign ra_data = regs[ra_addr];
    assign rb_data = regs[rb_addr];
    assign rc_data = regs[rc_addr];
endmodule

// File: rtl/alu_seq.sv
// alu_seq: 3-cycle instruction sequencer around an external combinational ALU.
// Define ALU_SEQ_ERR_EN to reject illegal opcodes (no writeback, err pulse).
module alu_seq import alu_seq_pkg::*; #(
    parameter int DW = 16,
    parameter int NREG = 8,
    localparam int AW = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [4:0]    instr_op,
    input  logic [AW-1:0] instr_rd,
    input  logic [AW-1:0] instr_rs1,
    input  logic [AW-1:0] instr_rs2,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [4:0]    alu_f,
    output logic          alu_cin,
    input  logic [DW-1:0] alu_result,
    input  logic [5:0]    alu_status,
    output logic          done,
    output logic          err,
    output logic [5:0]    flags,
    output logic [DW-1:0] result_out
);
    state_t        state, state_nx;
    logic [AW-1:0] rd_q;
    logic [DW-1:0] ra_data, rb_data;
    logic          accept, legal, wb_we;
`ifdef ALU_SEQ_ERR_EN
    assign legal = op_legal(alu_f);
`else
    assign legal = 1'b1;
`endif
    assign instr_ready = state == IDLE;
    assign wr_ready = state == IDLE;
    assign accept = instr_valid & instr_ready;
    assign wb_we = state == ISSUE && legal;
    assign alu_cin = state == ISSUE && flags[FLAG_C];
    assign done = state == DONE;
    assign err = done && !legal;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? (accept ? ISSUE : IDLE) : state == ISSUE ? DONE : IDLE;
    end
    // operands are latched from the pre-write register values, so a same-edge host write is not seen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a <= '0;
            alu_b <= '0;
            alu_f <= '0;
            rd_q <= '0;
            flags <= '0;
            result_out <= '0;
        end else begin
            if (accept) begin
                alu_a <= ra_data;
                alu_b <= rb_data;
                alu_f <= instr_op;
                rd_q <= instr_rd;
            end
            if (wb_we) begin
                flags <= alu_status;
                result_out <= alu_result;
            end
        end
    end
    alu_seq_regfile #(.DW(DW), .NREG(NREG)) u_regfile (
        .clk(clk),
        .rst(rst),
        .host_we(wr_en & wr_ready),
        .host_addr(wr_addr),
        .host_data(wr_data),
        .wb_we(wb_we),
        .wb_addr(rd_q),
        .wb_data(alu_result),
        .ra_addr(instr_rs1),
        .ra_data(ra_data),
        .rb_addr(instr_rs2),
        .rb_data(rb_data),
        .rc_addr(rd_addr),
        .rc_data(rd_data)
    );
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq against a register-array model and a bench-side ALU.
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0, instr_ready;
    logic [4:0]  instr_op = '0;
    logic [2:0]  instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
    logic        wr_en = 1'b0, wr_ready;
    logic [2:0]  wr_addr = '0, rd_addr = '0;
    logic [15:0] wr_data = '0, rd_data;
    logic [15:0] alu_a, alu_b, alu_result, result_out;
    logic [4:0]  alu_f;
    logic        alu_cin, done, err;
    logic [5:0]  alu_status, flags;

    logic [15:0] m_reg [8];
    logic [5:0]  m_flags;
    logic [15:0] m_res;
    logic [4:0]  p_op;
    logic [2:0]  p_rd;
    logic [15:0] p_a, p_b;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_seq dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
        .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_status(alu_status),
        .done(done), .err(err), .flags(flags), .result_out(result_out)
    );

    // external ALU: returns {C,Z,N,V,P,A, result}
    function automatic logic [21:0] alu_fn(logic [4:0] f, logic [15:0] a, logic [15:0] b, logic cin);
        logic [15:0] be, r;
        logic [16:0] s;
        logic [4:0]  n;
        logic        c0, arith, c, v, ac;
        arith = 1'b1;
        be = b;
        c0 = 1'b0;
        case (f)
            5'd1: begin be = 16'h0000; c0 = 1'b1; end
            5'd3: be = 16'hFFFF;
            5'd4: ;
            5'd5: c0 = cin;
            5'd6: begin be = ~b; c0 = 1'b1; end
            5'd7: begin be = ~b; c0 = cin; end
            default: arith = 1'b0;
        endcase
        s = {1'b0, a} + {1'b0, be} + {16'b0, c0};
        n = {1'b0, a[3:0]} + {1'b0, be[3:0]} + {4'b0, c0};
        if (arith) begin
            r = s[15:0];
            c = s[16];
            v = (a[15] == be[15]) && (r[15] != a[15]);
            ac = n[4];
        end else begin
            c = 1'b0;
            v = 1'b0;
            ac = 1'b0;
            case (f)
                5'd8: r = a & b;
                5'd9: r = a | b;
                5'd10: r = a ^ b;
                5'd11: r = ~a;
                default: r = f[4:3] == 2'b10 ? a >> f[2:0] : 16'h0000;
            endcase
        end
        return {c, r == 16'h0000, r[15], v, ^r[7:0], ac, r};
    endfunction

    always_comb {alu_status, alu_result} = alu_fn(alu_f, alu_a, alu_b, alu_cin);

    function automatic logic writes_back(logic [4:0] op);
`ifdef ALU_SEQ_ERR_EN
        return op == 5'd1 || op == 5'd3 || (op >= 5'd4 && op <= 5'd11) || (op >= 5'd16 && op <= 5'd23);
`else
        return op == op;
`endif
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic read_check(string tag, logic [2:0] a, logic [15:0] exp);
        rd_addr = a;
        #1;
        check(tag, rd_data, exp);
    endtask

    task automatic check_all(string tag);
        for (int i = 0; i < 8; i++) read_check(tag, 3'(i), m_reg[i]);
    endtask

    task automatic host_write(logic [2:0] a, logic [15:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        #1;
        check("wr_ready_idle", wr_ready, 1);
        m_reg[a] = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic accept(logic [4:0] op, logic [2:0] rd, logic [2:0] rs1, logic [2:0] rs2,
                          logic w, logic [2:0] wa, logic [15:0] wd);
        instr_valid = 1'b1;
        instr_op = op;
        instr_rd = rd;
        instr_rs1 = rs1;
        instr_rs2 = rs2;
        wr_en = w;
        wr_addr = wa;
        wr_data = wd;
        #1;
        check("instr_ready_idle", instr_ready, 1);
        p_op = op;
        p_rd = rd;
        p_a = m_reg[rs1];
        p_b = m_reg[rs2];
        if (w) m_reg[wa] = wd;
        step();
        instr_valid = 1'b0;
        wr_en = 1'b0;
    endtask

    // runs ISSUE, DONE and the return to IDLE; junk drives ignored requests while busy
    task automatic finish(logic junk);
        logic [21:0] o;
        logic ok;
        if (junk) begin
            instr_valid = 1'b1;
            instr_op = 5'($urandom);
            wr_en = 1'b1;
            wr_addr = 3'($urandom);
            wr_data = 16'($urandom);
        end
        #1;
        check("issue_alu_a", alu_a, p_a);
        check("issue_alu_b", alu_b, p_b);
        check("issue_alu_f", alu_f, p_op);
        check("issue_cin", alu_cin, m_flags[5]);
        check("issue_done", done, 0);
        check("issue_busy", {instr_ready, wr_ready}, 0);
        o = alu_fn(p_op, p_a, p_b, m_flags[5]);
        ok = writes_back(p_op);
        if (ok) begin
            m_reg[p_rd] = o[15:0];
            m_flags = o[21:16];
            m_res = o[15:0];
        end
        step();
        read_check("done_rd_data", p_rd, m_reg[p_rd]);
        check("done_pulse", done, 1);
        check("done_err", err, !ok);
        check("done_flags", flags, m_flags);
        check("done_result", result_out, m_res);
        check("done_busy", {instr_ready, wr_ready}, 0);
        step();
        if (junk) begin
            instr_valid = 1'b0;
            wr_en = 1'b0;
        end
        #1;
        check("idle_done", {done, err}, 0);
        check("idle_ready", {instr_ready, wr_ready}, 2'b11);
        check("idle_hold", {alu_a, alu_b, 11'b0, alu_f}, {p_a, p_b, 11'b0, p_op});
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_flags = '0;
        m_res = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_ready", {instr_ready, wr_ready}, 2'b11);
        check("reset_outs", {done, err, flags, result_out, alu_cin}, 0);
        check("reset_alu", {alu_a, alu_b, alu_f}, 0);
        check_all("reset_regs");

        host_write(3'd1, 16'h7FFF);
        host_write(3'd2, 16'h0001);
        accept(5'b00100, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0);
        finish(1'b0);
        read_check("add_r3", 3'd3, 16'h8000);
        check("add_flags", flags, 6'b001101);

        host_write(3'd1, 16'hFFFF);
        accept(5'b00100, 3'd4, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0);
        finish(1'b0);
        read_check("add_r4", 3'd4, 16'h0000);
        check("add_carry", flags[5], 1);
        accept(5'b00101, 3'd5, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0);
        #1;
        check("adc_cin", alu_cin, 1);
        finish(1'b0);
        read_check("adc_r5", 3'd5, 16'h0001);

        accept(5'b01100, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0);
        finish(1'b0);
`ifdef ALU_SEQ_ERR_EN
        read_check("illegal_r3", 3'd3, 16'h8000);
`else
        read_check("illegal_r3", 3'd3, 16'h0000);
`endif

        host_write(3'd1, 16'h0005);
        host_write(3'd2, 16'h0006);
        accept(5'b00100, 3'd6, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_flags = '0;
        m_res = '0;
        check("rst_issue_outs", {done, err, flags, result_out, alu_cin}, 0);
        check("rst_issue_alu", {alu_a, alu_b, alu_f}, 0);
        check("rst_issue_ready", {instr_ready, wr_ready}, 2'b11);
        step();
        rst = 1'b0;
        #1;
        check("rst_release_ready", {instr_ready, wr_ready}, 2'b11);
        read_check("rst_r6", 3'd6, 16'h0000);
        check_all("rst_regs");

        host_write(3'd7, 16'h0BAD);
        accept(5'b01010, 3'd1, 3'd2, 3'd3, 1'b0, 3'd0, 16'h0);
        instr_valid = 1'b1;
        instr_op = 5'b01000;
        instr_rd = 3'd0;
        instr_rs1 = 3'd7;
        instr_rs2 = 3'd7;
        wr_en = 1'b1;
        wr_addr = 3'd7;
        wr_data = 16'h1234;
        finish(1'b0);
        read_check("held_wr_ignored", 3'd7, 16'h0BAD);
        accept(5'b01000, 3'd0, 3'd7, 3'd7, 1'b1, 3'd7, 16'h1234);
        finish(1'b0);
        read_check("held_instr_r0", 3'd0, 16'h0BAD);
        read_check("held_wr_r7", 3'd7, 16'h1234);

        host_write(3'd1, 16'h0010);
        accept(5'b00001, 3'd2, 3'd1, 3'd0, 1'b1, 3'd1, 16'h00AA);
        finish(1'b0);
        read_check("inc_r2", 3'd2, 16'h0011);
        read_check("inc_r1", 3'd1, 16'h00AA);

        for (int k = 0; k < 40; k++) begin
            accept(5'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                   1'($urandom), 3'($urandom), 16'($urandom));
            finish(1'($urandom));
        end
        check_all("final_regs");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
